// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   16-tap FIR filter that walks the taps one per clock through a single
//   shared multiplier and accumulator. Coefficients are written into a shadow
//   bank and copied into the active bank only while no MAC sequence is
//   running, so a filter result is always computed with one coherent bank.
//
// Ports
//   clk, resetn           : clock (rising edge), synchronous active-low reset
//   s_data/s_valid/s_ready: signed input sample handshake
//   m_data/m_valid        : signed filter result, m_valid is a 1-cycle strobe
//   cfg_we/addr/data      : shadow coefficient write port
//   cfg_commit            : request shadow->active copy
//   cfg_pending           : copy requested but not yet applied
//   busy                  : MAC sequence in progress
module fir_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH+15:0] m_data,
  output logic                  m_valid,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [15:0]           cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_pending,
  output logic                  busy
);

  localparam int ACC_W = DATA_WIDTH + 16;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [3:0]            r_k;
  logic [3:0]            r_ptr;
  logic [DATA_WIDTH-1:0] r_delay  [NUM_TAPS];
  logic [15:0]           r_shadow [NUM_TAPS];
  logic [15:0]           r_active [NUM_TAPS];
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      r_m_data;
  logic                  r_m_valid;
  logic                  r_pending;

  logic                  w_accept;
  logic                  w_apply;
  logic                  w_last;
  logic [3:0]            w_tap_idx;
  logic signed [ACC_W-1:0] w_coef_ext;
  logic signed [ACC_W-1:0] w_samp_ext;
  logic [ACC_W-1:0]      w_product;
  logic [ACC_W-1:0]      w_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and handshake; a pending commit takes the IDLE edge so no
  // sample is accepted on the same edge the banks are swapped.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_apply      = 1'b0;
    w_last       = 1'b0;
    s_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = resetn && !r_pending;
        if (r_pending) begin
          w_apply = 1'b1;
        end else if (s_valid && s_ready) begin
          w_accept     = 1'b1;
          w_state_next = MAC;
        end
      end
      MAC: begin
        if (r_k == 4'd15) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // Newest sample sits one below the write pointer; tap k looks k further back.
  assign w_tap_idx  = r_ptr - 4'd1 - r_k;
  // Operands are sign-extended to the accumulator width so the product is
  // already in accumulator format; only the low ACC_W bits are kept.
  assign w_coef_ext = {{DATA_WIDTH{r_active[r_k][15]}}, r_active[r_k]};
  assign w_samp_ext = {{16{r_delay[w_tap_idx][DATA_WIDTH-1]}}, r_delay[w_tap_idx]};
  assign w_product  = w_coef_ext * w_samp_ext;
  assign w_sum      = r_acc + w_product;

  // Datapath, delay line and coefficient banks
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_k       <= '0;
      r_ptr     <= '0;
      r_acc     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        r_delay[i]  <= '0;
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_m_valid <= 1'b0;

      if (cfg_we) r_shadow[cfg_addr] <= cfg_data;

      // The copy merges a same-edge shadow write so it is never lost.
      if (w_apply) begin
        r_pending <= 1'b0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
          r_active[i] <= (cfg_we && (cfg_addr == 4'(i))) ? cfg_data : r_shadow[i];
        end
      end else if (cfg_commit) begin
        r_pending <= 1'b1;
      end

      if (w_accept) begin
        r_delay[r_ptr] <= s_data;
        r_ptr          <= r_ptr + 4'd1;
        r_acc          <= '0;
        r_k            <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_sum;
        r_k   <= r_k + 4'd1;
        if (w_last) begin
          r_m_data  <= w_sum;
          r_m_valid <= 1'b1;
        end
      end
    end
  end

  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign cfg_pending = r_pending;
  assign busy        = (r_state == MAC);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: scenario tasks driven from one initial
// block, expected results from a history-based FIR model (plain sum of
// coef[k] * x[n-k] over the sample history, truncated to 32 bits).
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_pending;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fir_mac_sequencer #(.DATA_WIDTH(16), .NUM_TAPS(16)) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  longint      m_hist   [16];
  logic [15:0] m_shadow [16];
  logic [15:0] m_active [16];

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_hist[i] = 0; m_shadow[i] = '0; m_active[i] = '0;
    end
  endfunction

  function automatic logic [31:0] model_accept(input logic [15:0] x);
    longint s;
    for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = longint'($signed(x));
    s = 0;
    for (int k = 0; k < 16; k++) s += longint'($signed(m_active[k])) * m_hist[k];
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; s_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(input int a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    m_shadow[a] = d;
  endtask

  // Commit from IDLE: one edge raises pending, the next IDLE edge copies.
  task automatic commit_settle();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    m_active = m_shadow;
  endtask

  task automatic write_commit(input int a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_commit = 1'b1; cfg_addr = 4'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    m_shadow[a] = d;
    tick();
    m_active = m_shadow;
  endtask

  // Offer one sample, return the result and edges from accept to m_valid
  // (-1 when the bound expires).
  task automatic send_sample(input logic [15:0] x, output logic [31:0] got,
                             output logic [31:0] exp, output int lat);
    int n;
    n = 0;
    while (!s_ready && n < 60) begin tick(); n++; end
    s_data = x; s_valid = 1'b1;
    exp = model_accept(x);
    tick();
    s_valid = 1'b0; s_data = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (m_valid) begin lat = c; break; end
    end
    got = m_data;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
    tick();
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: s_ready=%b expected 0", s_ready); end
    tick();
    resetn = 1'b1; s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: s_ready=%b expected 1", s_ready); end
    checks++;
    if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: m_data=%h expected 0", m_data); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: m_valid=%b expected 0", m_valid); end
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: cfg_pending=%b expected 0", cfg_pending); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
    model_clear();
  endtask

  task automatic test_impulse(input string tag);
    logic [31:0] got, exp, want;
    int lat;
    for (int k = 0; k < 16; k++) cfg_write(k, 16'(k + 1));
    commit_settle();
    for (int i = 0; i < 17; i++) begin
      send_sample((i == 0) ? 16'd1 : 16'd0, got, exp, lat);
      want = (i < 16) ? 32'(i + 1) : 32'd0;
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s_data[%0d]: m_data=%h expected %h", tag, i, got, want); end
      checks++;
      if (lat !== 16) begin errors++; $display("FAIL %s_latency[%0d]: got %0d expected 16", tag, i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int mv_cyc[$];
    logic [31:0] expq[$];
    logic [31:0] want;
    logic [15:0] x;
    int busy_cnt;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 200 && mv_cyc.size() < 4; cyc++) begin
      x = 16'($urandom);
      s_data = x;
      s_valid = (acc_cyc.size() < 4);
      if (s_valid && s_ready) begin
        acc_cyc.push_back(cyc);
        expq.push_back(model_accept(x));
      end
      tick();
      if (busy) busy_cnt++;
      if (m_valid) begin
        mv_cyc.push_back(cyc);
        want = (expq.size() > 0) ? expq.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (m_data !== want) begin errors++; $display("FAIL b2b_data[%0d]: m_data=%h expected %h", mv_cyc.size()-1, m_data, want); end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (mv_cyc.size() != 4 || acc_cyc.size() != 4) begin
      errors++; $display("FAIL b2b_count: accepts=%0d results=%0d expected 4 and 4", acc_cyc.size(), mv_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mv_cyc[i] - acc_cyc[i] != 16) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 16", i, mv_cyc[i] - acc_cyc[i]); end
        if (i > 0) begin
          checks++;
          if (acc_cyc[i] - acc_cyc[i-1] != 17) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 17", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
      end
    end
    checks++;
    if (busy_cnt != 64) begin errors++; $display("FAIL b2b_busy: busy cycles=%0d expected 64", busy_cnt); end
  endtask

  task automatic test_commit_busy();
    logic [31:0] got, exp;
    int lat;
    do_reset();
    for (int k = 0; k < 16; k++) cfg_write(k, 16'd1);
    commit_settle();
    checks++;
    if (cfg_pending !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL cb_applied: cfg_pending=%b s_ready=%b expected 0 1", cfg_pending, s_ready);
    end
    for (int k = 0; k < 16; k++) cfg_write(k, 16'd2);
    s_data = 16'd5; s_valid = 1'b1;
    exp = model_accept(16'd5);
    tick();
    s_valid = 1'b0;
    tick(); tick(); tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    lat = 4;
    checks++;
    if (cfg_pending !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL cb_pending_set: cfg_pending=%b busy=%b s_ready=%b expected 1 1 0", cfg_pending, busy, s_ready);
    end
    while (!m_valid && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL cb_latency: got %0d expected 16", lat); end
    checks++;
    if (m_data !== 32'd5 || m_data !== exp) begin errors++; $display("FAIL cb_result_old_bank: m_data=%h expected %h", m_data, 32'd5); end
    checks++;
    if (cfg_pending !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL cb_pending_held: cfg_pending=%b s_ready=%b expected 1 0", cfg_pending, s_ready);
    end
    tick();
    m_active = m_shadow;
    checks++;
    if (cfg_pending !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL cb_apply_edge: cfg_pending=%b s_ready=%b m_valid=%b expected 0 1 0", cfg_pending, s_ready, m_valid);
    end
    checks++;
    if (m_data !== 32'd5) begin errors++; $display("FAIL cb_hold: m_data=%h expected 5", m_data); end
    send_sample(16'd1, got, exp, lat);
    checks++;
    if (got !== 32'd12 || got !== exp) begin errors++; $display("FAIL cb_result_new_bank: m_data=%h expected %h", got, 32'd12); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, exp;
    int lat;
    do_reset();
    for (int k = 0; k < 16; k++) cfg_write(k, 16'h8000);
    commit_settle();
    for (int i = 0; i < 16; i++) begin
      send_sample(16'h8000, got, exp, lat);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap_data[%0d]: m_data=%h expected %h", i, got, exp); end
    end
    checks++;
    if (got !== 32'h0000_0000) begin errors++; $display("FAIL wrap_final: m_data=%h expected 00000000", got); end
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] got, exp;
    int lat;
    bit saw_valid;
    for (int k = 0; k < 16; k++) cfg_write(k, 16'(k + 1));
    commit_settle();
    for (int i = 0; i < 3; i++) send_sample(16'($urandom), got, exp, lat);
    s_data = 16'($urandom_range(1, 32767)); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: busy=%b expected 1", busy); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_clear();
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_valid) saw_valid = 1'b1;
      tick();
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL rm_no_strobe: m_valid seen=1 expected 0"); end
    checks++;
    if (m_data !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_cleared: m_data=%h busy=%b expected 0 0", m_data, busy); end
    test_impulse("rm_impulse");
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    int lat;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 15; k++) cfg_write(k, 16'($urandom));
      write_commit(15, 16'($urandom));
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send_sample(16'($urandom), got, exp, lat);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_data[%0d.%0d]: m_data=%h expected %h", b, i, got, exp); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL rand_latency[%0d.%0d]: got %0d expected 16", b, i, lat); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_impulse("impulse");
    test_back_to_back();
    test_commit_busy();
    test_wrap();
    test_reset_mid_mac();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
